stopwatch_display_scan: RTL and testbench

Multiplexed 4-digit 7-segment display driver that consumes the four BCD digits produced by the stopwatch counter chain and drives a common-anode/cathode display. Time-multiplexes one digit per scan slot, snapshots the digit inputs only at frame boundaries so that no torn values are shown, and supports display hold, leading-zero blanking, invalid-code indication and anti-ghosting guard time. Sits between the stopwatch core and the board display pins.

---
 rtl/stopwatch_display_scan.sv | 114 +++++++++++
 tb/tb_stopwatch_display_scan.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment driver. Digits are captured only at frame boundaries,
// with display hold, leading-zero blanking, a dash for non-BCD codes and anode guard time.
module stopwatch_display_scan #(
    parameter int unsigned SCAN_DIV   = 2500,
    parameter int unsigned GUARD      = 4,
    parameter int unsigned DP_POS     = 2,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_C   = PW'(GUARD);
    localparam logic [1:0]    DP_IDX    = 2'(DP_POS);
    localparam bit            BLANK3_EN = (DP_POS < 3);
    localparam bit            BLANK2_EN = (DP_POS < 2);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [1:0]    hold_sync_q;
    logic          hold_s;
    logic          frame_end;

    logic [3:0] cur_digit;
    logic       an_on;
    logic       blank3, blank2, cur_blank;
    logic [6:0] seg_act;
    logic [3:0] an_act;
    logic       dp_act;

    function automatic logic [6:0] decode(input logic [3:0] d);
        unique case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign hold_s    = hold_sync_q[1];
    assign frame_end = (pcnt_q == PCNT_LAST) && (idx_q == 2'd3);

    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        idx_d  = idx_q;
        snap_d = snap_q;
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        if (frame_end && !hold_s) begin
            snap_d = {digit3, digit2, digit1, digit0};
        end
    end

    always_comb begin
        cur_digit = snap_q[4*idx_q +: 4];
        an_on     = (pcnt_q >= GUARD_C);
        // Zero is the only blankable code, so invalid codes are never blanked.
        blank3    = BLANK3_EN && (snap_q[15:12] == 4'd0);
        blank2    = BLANK2_EN && blank3 && (snap_q[11:8] == 4'd0);
        cur_blank = ((idx_q == 2'd3) && blank3) || ((idx_q == 2'd2) && blank2);
        seg_act   = '0;
        an_act    = '0;
        dp_act    = 1'b0;
        if (an_on) begin
            an_act  = 4'b0001 << idx_q;
            seg_act = cur_blank ? 7'h00 : decode(cur_digit);
            dp_act  = (idx_q == DP_IDX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            hold_sync_q <= '0;
            frame_done  <= 1'b0;
            seg         <= {7{ACTIVE_LOW}};
            dp          <= ACTIVE_LOW;
            an          <= {4{ACTIVE_LOW}};
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            hold_sync_q <= {hold_sync_q[0], hold};
            frame_done  <= frame_end;
            seg         <= seg_act ^ {7{ACTIVE_LOW}};
            dp          <= dp_act ^ ACTIVE_LOW;
            an          <= an_act ^ {4{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench: two instances (active-low and active-high pins) with SCAN_DIV=8, GUARD=2.
module tb_stopwatch_display_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       hold;
    logic [6:0] seg_l, seg_h;
    logic       dp_l, dp_h;
    logic [3:0] an_l, an_h;
    logic       fd_l, fd_h;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    stopwatch_display_scan #(
        .SCAN_DIV(8), .GUARD(2), .DP_POS(2), .ACTIVE_LOW(1'b1)
    ) dut_l (
        .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .hold(hold), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
    );

    stopwatch_display_scan #(
        .SCAN_DIV(8), .GUARD(2), .DP_POS(2), .ACTIVE_LOW(1'b0)
    ) dut_h (
        .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .hold(hold), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to rising edge number e after reset release, then sample 1 time unit later.
    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3;
        digit2 = d2;
        digit1 = d1;
        digit0 = d0;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", {1'b0, seg_l}, 8'h7F);
        check("rst_dp", {7'b0, dp_l}, 8'h01);
        check("rst_an", {4'b0, an_l}, 8'h0F);
        check("rst_fd", {7'b0, fd_l}, 8'h00);
        reset = 1'b0;
        cyc   = 0;

        step_to(2);  check("guard_an_e2", {4'b0, an_l}, 8'h0F);
        step_to(3);  check("an0_e3", {4'b0, an_l}, 8'h0E);
        check("zero_seg_e3", {1'b0, seg_l}, 8'h40);
        check("dp_off_e3", {7'b0, dp_l}, 8'h01);
        step_to(10); check("guard_an_e10", {4'b0, an_l}, 8'h0F);
        step_to(11); check("an1_e11", {4'b0, an_l}, 8'h0D);
        step_to(19); check("an2_e19", {4'b0, an_l}, 8'h0B);
        check("dp_on_e19", {7'b0, dp_l}, 8'h00);
        step_to(27); check("an3_e27", {4'b0, an_l}, 8'h07);
        check("blank3_e27", {1'b0, seg_l}, 8'h7F);
        step_to(31); check("fd_e31", {7'b0, fd_l}, 8'h00);
        step_to(32); check("fd_e32", {7'b0, fd_l}, 8'h01);
        check("fd_h_e32", {7'b0, fd_h}, 8'h01);
        step_to(33); check("fd_e33", {7'b0, fd_l}, 8'h00);

        // Snapshot 1,2,3,4 shown; a mid-frame digit0 change waits for the next frame end.
        step_to(34); check("pol_guard_an", {4'b0, an_h}, 8'h00);
        check("pol_guard_seg", {1'b0, seg_h}, 8'h00);
        step_to(35); check("s0_4_e35", {1'b0, seg_l}, 8'h19);
        check("pol_an_e35", {4'b0, an_h}, 8'h01);
        check("pol_seg_e35", {1'b0, seg_h}, 8'h66);
        step_to(36); digit0 = 4'd9;
        step_to(40); check("coherent_e40", {1'b0, seg_l}, 8'h19);
        step_to(43); check("s1_3_e43", {1'b0, seg_l}, 8'h30);
        step_to(51); check("s2_2_e51", {1'b0, seg_l}, 8'h24);
        check("dp_e51", {7'b0, dp_l}, 8'h00);
        step_to(59); check("s3_1_e59", {1'b0, seg_l}, 8'h79);
        step_to(67); check("s0_9_e67", {1'b0, seg_l}, 8'h10);

        // Leading-zero blanking: 0,0,5,7.
        set_digits(4'd0, 4'd0, 4'd5, 4'd7);
        step_to(99);  check("blk_s0_e99", {1'b0, seg_l}, 8'h78);
        step_to(107); check("blk_s1_e107", {1'b0, seg_l}, 8'h12);
        step_to(115); check("blk_s2_e115", {1'b0, seg_l}, 8'h40);
        check("blk_dp_e115", {7'b0, dp_l}, 8'h00);
        step_to(123); check("blk_s3_seg", {1'b0, seg_l}, 8'h7F);
        check("blk_s3_an", {4'b0, an_l}, 8'h07);
        check("blk_s3_an_h", {4'b0, an_h}, 8'h08);
        check("blk_s3_seg_h", {1'b0, seg_h}, 8'h00);

        // Invalid code shows a dash.
        digit1 = 4'hC;
        step_to(139); check("dash_s1", {1'b0, seg_l}, 8'h3F);

        // Hold keeps 1234 while inputs read 5678.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        step_to(163); check("hold_pre_s0", {1'b0, seg_l}, 8'h19);
        hold = 1'b1;
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        step_to(195); check("hold_f1", {1'b0, seg_l}, 8'h19);
        step_to(227); check("hold_f2", {1'b0, seg_l}, 8'h19);
        step_to(259); check("hold_f3", {1'b0, seg_l}, 8'h19);
        step_to(260); hold = 1'b0;
        step_to(283); check("hold_rel_s3", {1'b0, seg_l}, 8'h79);
        step_to(290); check("pol_guard_an2", {4'b0, an_h}, 8'h00);
        step_to(291); check("rel_s0_8", {1'b0, seg_l}, 8'h00);
        check("pol8_seg", {1'b0, seg_h}, 8'h7F);
        check("pol8_an", {4'b0, an_h}, 8'h01);

        // Asynchronous reset mid-slot.
        step_to(294);
        reset = 1'b1;
        #1;
        check("arst_seg", {1'b0, seg_l}, 8'h7F);
        check("arst_an", {4'b0, an_l}, 8'h0F);
        check("arst_dp", {7'b0, dp_l}, 8'h01);
        check("arst_seg_h", {1'b0, seg_h}, 8'h00);
        check("arst_an_h", {4'b0, an_h}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
